// File: rtl/conf_int_add_apx_arbiter_pkg.sv
// Shared definitions for the approximate/accurate adder arbiter.
//   state_t  : controller states (IDLE, EXEC, RESP)
//   RESULT_W : width of a full-precision sum (24-bit operands plus carry)
//   ACC_W    : width of one requester operand
//   clog2    : index width helper, never narrower than one bit
package conf_int_add_apx_arbiter_pkg;

  localparam int RESULT_W = 25;
  localparam int ACC_W    = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int width;
    for (width = 0; (1 << width) < value; width++) begin
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/conf_int_add_apx_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the external shared adder.
//   req_valid/req_ready/req_a/req_b/req_acc : per-requester request side
//   add_a/add_b/add_acc_sel/add_d_acc/add_d : shared adder wrapper drive/result
//   rsp_valid/rsp_ready/rsp_d/rsp_id/rsp_acc: single response channel
// slave  : the arbiter's view
// master : the environment's view (requesters, adder wrapper, response sink)
interface conf_int_add_apx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DPW     = 16
);
  import conf_int_add_apx_arbiter_pkg::*;

  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*ACC_W-1:0] req_a;
  logic [NUM_REQ*ACC_W-1:0] req_b;
  logic [NUM_REQ-1:0]       req_acc;

  logic [DPW-1:0]           add_a;
  logic [DPW-1:0]           add_b;
  logic                     add_acc_sel;
  logic [RESULT_W-1:0]      add_d_acc;
  logic [RESULT_W-1:0]      add_d;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [RESULT_W-1:0]      rsp_d;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_acc;

  modport slave (
    input  req_valid, req_a, req_b, req_acc, add_d, rsp_ready,
    output req_ready, add_a, add_b, add_acc_sel, add_d_acc,
           rsp_valid, rsp_d, rsp_id, rsp_acc
  );

  modport master (
    output req_valid, req_a, req_b, req_acc, add_d, rsp_ready,
    input  req_ready, add_a, add_b, add_acc_sel, add_d_acc,
           rsp_valid, rsp_d, rsp_id, rsp_acc
  );

endinterface

// File: rtl/conf_int_add_apx_arbiter_rr_arbiter.sv
// Round-robin picker. The search starts one past the last granted index and
// wraps; the first requesting index found wins.
//   req   : request vector
//   ptr   : index granted last time
//   grant : one-hot winner (all zero when nobody requests)
//   idx   : binary index of the winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  int              cand;
  logic [ID_W-1:0] cidx;
  logic            found;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = ID_W'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/conf_int_add_apx_arbiter.sv
// Arbitrates NUM_REQ requesters onto one external approximate/accurate adder.
// A granted op occupies EXEC for 1 cycle (approximate) or ACC_LAT cycles
// (accurate), then the result is held in RESP until the sink accepts it.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : request, shared-adder and response signals (slave modport)
module conf_int_add_apx_arbiter
  import conf_int_add_apx_arbiter_pkg::*;
#(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int NUM_REQ            = 4,
  parameter int ACC_LAT            = 2
) (
  input logic                      clk,
  input logic                      rst,
  conf_int_add_apx_arbiter_if.slave bus
);

  localparam int DPW  = DATA_PATH_BITWIDTH;
  localparam int ID_W = clog2(NUM_REQ);

  if (OP_BITWIDTH < 1 || DPW < 1 || DPW > ACC_W || NUM_REQ < 2 || NUM_REQ > 8 ||
      ACC_LAT < 1 || ACC_LAT > 15) begin : g_bad_cfg
    $error("conf_int_add_apx_arbiter: parameter out of legal range");
  end

  state_t              state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     lat_id;
  logic [ACC_W-1:0]    lat_a;
  logic [ACC_W-1:0]    lat_b;
  logic                lat_acc;
  logic [3:0]          cnt;
  logic [RESULT_W-1:0] rsp_d;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_acc;

  logic [NUM_REQ-1:0]  rr_grant;
  logic [ID_W-1:0]     rr_idx;
  logic                slot_free;
  logic                do_grant;
  logic                in_exec;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (last_grant),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // The response slot is free when idle, or when the held response is being
  // accepted this cycle; that lets RESP hand straight over to the next op.
  assign slot_free = (state == IDLE) || ((state == RESP) && bus.rsp_ready);

  // NOTE: the grant strobe is combinational so requester data transfers on the
  // same edge the strobe is seen; it is qualified with rst so no requester is
  // accepted while the block is held in reset.
  assign do_grant      = rst && slot_free && (|bus.req_valid);
  assign bus.req_ready = do_grant ? rr_grant : '0;

  // The adder sees the latched operation only while it is executing.
  assign in_exec         = (state == EXEC);
  assign bus.add_a       = in_exec ? lat_a[ACC_W-1 -: DPW] : '0;
  assign bus.add_b       = in_exec ? lat_b[ACC_W-1 -: DPW] : '0;
  assign bus.add_acc_sel = in_exec && lat_acc;
  assign bus.add_d_acc   = in_exec ? ({1'b0, lat_a} + {1'b0, lat_b}) : '0;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_d     = rsp_d;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_acc   = rsp_acc;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      lat_id     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_acc    <= 1'b0;
      cnt        <= '0;
      rsp_d      <= '0;
      rsp_id     <= '0;
      rsp_acc    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (do_grant) state <= EXEC;
        EXEC: begin
          if (cnt == 4'd1) begin
            rsp_d   <= bus.add_d;
            rsp_id  <= lat_id;
            rsp_acc <= lat_acc;
            cnt     <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (bus.rsp_ready) state <= do_grant ? EXEC : IDLE;
        default: state <= IDLE;
      endcase

      // Grant bookkeeping; do_grant is only ever true in IDLE or RESP.
      if (do_grant) begin
        last_grant <= rr_idx;
        lat_id     <= rr_idx;
        lat_a      <= bus.req_a[int'(rr_idx)*ACC_W +: ACC_W];
        lat_b      <= bus.req_b[int'(rr_idx)*ACC_W +: ACC_W];
        lat_acc    <= bus.req_acc[rr_idx];
        cnt        <= bus.req_acc[rr_idx] ? 4'(ACC_LAT) : 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_conf_int_add_apx_arbiter.sv
// Self-checking bench: directed operation table plus hand-written sequences
// for back-pressure, mid-operation reset and round-robin ordering.
module tb_conf_int_add_apx_arbiter;
  import conf_int_add_apx_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DPW     = 16;
  localparam int ACC_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conf_int_add_apx_arbiter_if #(.NUM_REQ(NUM_REQ), .DPW(DPW)) bus ();

  // Model of the external shared adder wrapper.
  logic [DPW:0] apx_sum;
  assign apx_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign bus.add_d = bus.add_acc_sel ? bus.add_d_acc : {apx_sum, {(ACC_W-DPW){1'b0}}};

  conf_int_add_apx_arbiter #(
    .OP_BITWIDTH        (16),
    .DATA_PATH_BITWIDTH (DPW),
    .NUM_REQ            (NUM_REQ),
    .ACC_LAT            (ACC_LAT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [23:0] a;
    logic [23:0] b;
    logic        acc;
    logic [24:0] d;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int id, input logic [23:0] a, input logic [23:0] b, input logic acc);
    bus.req_a[id*24 +: 24] = a;
    bus.req_b[id*24 +: 24] = b;
    bus.req_acc[id]        = acc;
  endtask

  // Raise valid for one requester and wait for its strobe; returns with the
  // grant cycle current and valid already dropped one cycle later.
  task automatic request(input int id, output bit got);
    bus.req_valid[id] = 1'b1;
    #1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready[id]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) check("ready_onehot", 32'(bus.req_ready), 32'(4'b0001 << id));
    tick();
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    int lat;
    logic [24:0] exp_sum;
    load(v.id, v.a, v.b, v.acc);
    request(v.id, got);
    if (got) begin
      exp_sum = {1'b0, v.a} + {1'b0, v.b};
      check("exec_add_a", 32'(bus.add_a), 32'(v.a[23:8]));
      check("exec_add_b", 32'(bus.add_b), 32'(v.b[23:8]));
      check("exec_acc_sel", 32'(bus.add_acc_sel), 32'(v.acc));
      check("exec_d_acc", 32'(bus.add_d_acc), 32'(exp_sum));
      check("ready_pulse", 32'(bus.req_ready), 32'd0);
      wait_rsp(lat);
      check("latency", 32'(lat), v.acc ? 32'(ACC_LAT + 1) : 32'd2);
      check("rsp_d", 32'(bus.rsp_d), 32'(v.d));
      check("rsp_id", 32'(bus.rsp_id), 32'(v.id));
      check("rsp_acc", 32'(bus.rsp_acc), 32'(v.acc));
      check("drive_idle_resp", 32'(bus.add_d_acc), 32'd0);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("rsp_released", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          lat;
    int          order[5];
    int          n_grants;
    int          last_c;
    logic [3:0]  prev_ready;
    logic [3:0]  r;
    int          stray;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_acc   = '0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{0, 24'h123456, 24'h0000FF, 1'b0, 25'h0123400};
    vecs[1] = '{0, 24'h123456, 24'h0000FF, 1'b1, 25'h0123555};
    vecs[2] = '{1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 25'h1FFFE00};
    vecs[3] = '{1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 25'h1FFFFFE};
    vecs[4] = '{2, 24'h800000, 24'h800000, 1'b0, 25'h1000000};
    vecs[5] = '{3, 24'h0000FF, 24'h000001, 1'b0, 25'h0000000};
    vecs[6] = '{3, 24'h7FFFFF, 24'h000001, 1'b1, 25'h0800000};
    vecs[7] = '{2, 24'hABCDEF, 24'h111111, 1'b0, 25'h0BCDE00};

    // Reset state, with every requester asking.
    tick();
    tick();
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_d", 32'(bus.rsp_d), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_acc", 32'(bus.rsp_acc), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_sel", 32'(bus.add_acc_sel), 32'd0);
    check("rst_add_d_acc", 32'(bus.add_d_acc), 32'd0);
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();

    // Directed operation table.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-pressure: response held 5 cycles, a second requester waiting.
    load(0, 24'h123456, 24'h0000FF, 1'b0);
    load(1, 24'h010000, 24'h020000, 1'b0);
    request(0, got);
    bus.req_valid[1] = 1'b1;
    wait_rsp(lat);
    check("stall_first_d", 32'(bus.rsp_d), 32'h0123400);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_d", 32'(bus.rsp_d), 32'h0123400);
      check("stall_id", 32'(bus.rsp_id), 32'd0);
      check("stall_no_grant", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.rsp_ready    = 1'b0;
    bus.req_valid[1] = 1'b0;
    wait_rsp(lat);
    check("release_lat", 32'(lat), 32'd2);
    check("second_d", 32'(bus.rsp_d), 32'h0030000);
    check("second_id", 32'(bus.rsp_id), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during an accurate EXEC aborts the op.
    load(2, 24'h123456, 24'h0000FF, 1'b1);
    request(2, got);
    check("mid_exec_sel", 32'(bus.add_acc_sel), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_rsp_d", 32'(bus.rsp_d), 32'd0);
    check("abort_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("abort_add_a", 32'(bus.add_a), 32'd0);
    check("abort_add_sel", 32'(bus.add_acc_sel), 32'd0);
    check("abort_add_d_acc", 32'(bus.add_d_acc), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.rsp_valid) stray++;
    end
    check("abort_no_response", 32'(stray), 32'd0);

    // Round robin with all four held valid and the sink always ready.
    for (int i = 0; i < NUM_REQ; i++) load(i, 24'(i) << 16, 24'h000100, 1'b0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    #1;
    n_grants   = 0;
    last_c     = 0;
    prev_ready = '0;
    for (int c = 0; c < 40 && n_grants < 5; c++) begin
      r = bus.req_ready;
      if (r != '0) begin
        check("rr_onehot", 32'($onehot(r)), 32'd1);
        check("rr_pulse_width", 32'(prev_ready), 32'd0);
        if (n_grants > 0) check("rr_gap", 32'(c - last_c), 32'd2);
        order[n_grants] = 0;
        for (int b = 0; b < NUM_REQ; b++) if (r[b]) order[n_grants] = b;
        last_c = c;
        n_grants++;
      end
      prev_ready = r;
      if (n_grants < 5) tick();
    end
    check("rr_count", 32'(n_grants), 32'd5);
    check("rr_order0", 32'(order[0]), 32'd0);
    check("rr_order1", 32'(order[1]), 32'd1);
    check("rr_order2", 32'(order[2]), 32'd2);
    check("rr_order3", 32'(order[3]), 32'd3);
    check("rr_order4", 32'(order[4]), 32'd0);
    tick();
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    check("drain_idle", 32'(bus.rsp_valid), 32'd0);
    check("drain_no_grant", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conf_int_add_apx_arbiter.md
CONF_INT_ADD_APX_ARBITER -- requirements
Module: conf_int_add_apx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter OP_BITWIDTH, default 16, SHALL be the operator bit width, passed through to the shared adder.
REQ-003 Parameter DATA_PATH_BITWIDTH (DPW), default 16, SHALL be the approximate adder operand width; legal range 1..24.
REQ-004 Parameter NUM_REQ, default 4, SHALL be the number of requesters; legal range 2..8.
REQ-005 Parameter ACC_LAT, default 2, SHALL be the cycles an accurate op occupies; legal range 1..15.
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  per-requester grant/accept strobe
- req_a, req_b  in  NUM_REQ*24  packed 24-bit operands; requester i at [24i+23:24i]
- req_acc  in  NUM_REQ  1 = accurate mode wanted
- add_a, add_b  out  DPW  operands to the shared adder wrapper
- add_acc_sel  out  1  wrapper accurate select
- add_d_acc  out  25  accurate sum to the wrapper
- add_d  in  25  wrapper result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_d  out  25  result
- rsp_id  out  clog2(NUM_REQ)  requester index
- rsp_acc  out  1  mode used

Function
REQ-007 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-008 IDLE/RESP->EXEC: when any req_valid is high and the output slot is free (IDLE, or RESP with rsp_ready), the block SHALL grant one requester.
REQ-009 On grant, req_ready[i] SHALL be high for exactly that cycle.
- req_a, req_b and req_acc SHALL be latched that same cycle.
- No other req_ready bit SHALL be high.
REQ-010 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_REQ, the lowest index wins after wrap, and the pointer updates only on grant.
REQ-011 A requester SHALL be allowed to drop req_valid before it is granted without any error or side effect.
REQ-012 The EXEC cycle counter SHALL be 1 for approximate ops and ACC_LAT for accurate ops; at terminal count the block SHALL capture add_d into rsp_d and go to RESP.
REQ-013 In EXEC the shared-adder drive SHALL be:
- add_a = latched a[23:24-DPW]
- add_b = latched b[23:24-DPW]
- add_acc_sel = latched acc
- add_d_acc = a+b (full 25-bit)
REQ-014 Outside EXEC, add_a, add_b, add_acc_sel and add_d_acc SHALL all be 0.
REQ-015 Arithmetic: an approximate result SHALL equal {sum of the DPW-bit tops, (24-DPW) zeros}; an accurate result SHALL equal the 25-bit sum; no saturation SHALL be applied, and carry goes to bit 24.
REQ-016 In RESP, rsp_valid SHALL be 1 and rsp_d, rsp_id and rsp_acc SHALL stay stable until rsp_ready is sampled high.
REQ-017 On RESP with rsp_ready: with a pending request the block SHALL grant and go to EXEC in the same cycle (no bubble); otherwise it SHALL go to IDLE.
REQ-018 Accept rate: approximate back-to-back throughput SHALL be one op per 2 cycles.
REQ-019 Latency: a response SHALL appear 1+cnt cycles after the grant edge (cnt per REQ-012).

Reset
REQ-020 While rst is low the block SHALL be in IDLE.
REQ-021 Reset values: req_ready=0, rsp_valid=0, rsp_d=0, rsp_id=0, rsp_acc=0, last_grant=NUM_REQ-1 (requester 0 first), counter=0, and all adder drives 0.
REQ-022 Reset asserted mid-EXEC or mid-RESP SHALL abort the op with no response emitted.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, RESULT_W=25, ACC_W=24 and the clog2 function.
REQ-024 The round-robin picker SHALL be one sub-module, rr_arbiter (inputs: req vector, pointer; outputs: one-hot grant and index).
REQ-025 The shared adder wrapper SHALL be instantiated outside this block.

Verification (DPW=16, ACC_LAT=2, NUM_REQ=4)
REQ-026 req0 approximate, a=0x123456, b=0x0000FF -> rsp_d=0x0123400, rsp_id=0, response 2 cycles after grant.
REQ-027 Same operands in accurate mode -> rsp_d=0x0123555, rsp_acc=1, response 3 cycles after grant.
REQ-028 a=b=0xFFFFFF -> approximate rsp_d=0x1FFFE00; accurate rsp_d=0x1FFFFFE.
REQ-029 All four requesters held valid -> grant order 0,1,2,3,0; each req_ready is a single-cycle pulse.
REQ-030 rsp_ready held low for 5 cycles -> rsp_* stable throughout and no new grant; on release, the next grant occurs in the same cycle.
REQ-031 rst asserted during accurate EXEC -> all outputs 0 within the reset cycle; after release req0 wins first.
